logic_unit_pipe: RTL

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 24 ++
 rtl/logic_unit_core.sv | 45 ++++
 rtl/logic_unit_pipe.sv | 98 +++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the logic_unit pipeline: operation modes,
// output-stage states and transfer-counter sizing.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    MODE_AND   = 3'd0,
    MODE_OR    = 3'd1,
    MODE_XOR   = 3'd2,
    MODE_NAND  = 3'd3,
    MODE_NOR   = 3'd4,
    MODE_XNOR  = 3'd5,
    MODE_PASS0 = 3'd6,
    MODE_INV0  = 3'd7
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise reduction of NIN packed operands, selected by mode.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
) (
  input  logic [NIN*WIDTH-1:0] operands,
  input  mode_e                mode,
  output logic [WIDTH-1:0]     result
);

  // Running AND/OR/XOR chains; the last stage holds the full reduction.
  logic [WIDTH-1:0] and_chain [NIN];
  logic [WIDTH-1:0] or_chain  [NIN];
  logic [WIDTH-1:0] xor_chain [NIN];

  assign and_chain[0] = operands[0 +: WIDTH];
  assign or_chain[0]  = operands[0 +: WIDTH];
  assign xor_chain[0] = operands[0 +: WIDTH];

  generate
    for (genvar gi = 1; gi < NIN; gi++) begin : g_chain
      assign and_chain[gi] = and_chain[gi-1] & operands[gi*WIDTH +: WIDTH];
      assign or_chain[gi]  = or_chain[gi-1]  | operands[gi*WIDTH +: WIDTH];
      assign xor_chain[gi] = xor_chain[gi-1] ^ operands[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    result = '0;
    case (mode)
      MODE_AND:   result = and_chain[NIN-1];
      MODE_OR:    result = or_chain[NIN-1];
      MODE_XOR:   result = xor_chain[NIN-1];
      MODE_NAND:  result = ~and_chain[NIN-1];
      MODE_NOR:   result = ~or_chain[NIN-1];
      MODE_XNOR:  result = ~xor_chain[NIN-1];
      MODE_PASS0: result = operands[0 +: WIDTH];
      MODE_INV0:  result = ~operands[0 +: WIDTH];
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// One-deep valid/ready pipeline around logic_unit_core with a registered result.
// Define LOGIC_UNIT_PIPE_STAT_EN to build the saturating ops_count register.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIN*WIDTH-1:0] in_data,
  input  logic [2:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_red,
  output logic [CNT_W-1:0]     ops_count
);

  state_e           state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_red_reg;
  logic [WIDTH-1:0] core_result;
  logic             in_fire;
  logic             out_fire;

  logic_unit_core #(
    .WIDTH (WIDTH),
    .NIN   (NIN)
  ) u_core (
    .operands (in_data),
    .mode     (mode_e'(in_mode)),
    .result   (core_result)
  );

  assign in_ready  = !out_valid_reg || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_reg && out_ready;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_red   = out_red_reg;

  // While FULL, an input transfer implies out_ready, so it is always a
  // back-to-back replace rather than an overwrite of an unread result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_red_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_reg     <= ST_FULL;
            out_valid_reg <= 1'b1;
            out_data_reg  <= core_result;
            out_red_reg   <= |core_result;
          end
        end
        ST_FULL: begin
          if (in_fire) begin
            out_data_reg <= core_result;
            out_red_reg  <= |core_result;
          end else if (out_fire) begin
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGIC_UNIT_PIPE_STAT_EN
  logic [CNT_W-1:0] ops_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_count_reg <= '0;
    end else if (out_fire && (ops_count_reg != CNT_SAT)) begin
      ops_count_reg <= ops_count_reg + 1'b1;
    end
  end

  assign ops_count = ops_count_reg;
`else
  assign ops_count = '0;
`endif

endmodule
